// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage round-to-integral for a parameterised binary float.
// Stage 1 locates the rounding window, stage 2 applies the integer increment.
module fp_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 15,
    parameter int TAG_W = 4
) (
    input  logic                   core_clock_i,
    input  logic                   core_reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   in_data_i,
    input  logic [1:0]             in_mode_i,
    input  logic [TAG_W-1:0]       in_tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W+MAN_W:0]   out_data_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic                   out_inexact_o
);

    localparam int WIDTH = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_HALF = EXP_W'(BIAS - 1);
    localparam logic [EXP_W-1:0] EXP_INT  = EXP_W'(BIAS + MAN_W);
    localparam logic [MAN_W-1:0] MAN_ONES = '1;

    typedef enum logic [1:0] {
        CLS_PASS,
        CLS_SMALL,
        CLS_NORM
    } cls_e;

    typedef enum logic [1:0] {
        RM_FLOOR = 2'b00,
        RM_CEIL  = 2'b01,
        RM_TRUNC = 2'b10,
        RM_RNE   = 2'b11
    } rmode_e;

    typedef struct packed {
        cls_e             cls;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
        rmode_e           mode;
        logic [TAG_W-1:0] tag;
        logic [MAN_W-1:0] int_mask;
        logic             rnd;
        logic             sticky;
        logic             lsb;
    } s1_t;

    s1_t  s1_d;
    s1_t  s1_q;
    logic s1_valid;
    logic s1_advance;
    logic s2_ready;

    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_frac;
    logic             is_pass;
    logic             is_small;
    logic             in_nz;
    logic [EXP_W-1:0] unb;
    logic [MAN_W-1:0] disc_mask;
    logic [MAN_W-1:0] rb_mask;

    assign {in_sign, in_exp, in_frac} = in_data_i;

    assign is_pass   = (in_exp == EXP_ONES) | (in_exp >= EXP_INT);
    assign is_small  = in_exp < EXP_BIAS;
    assign in_nz     = (in_exp != '0) | (in_frac != '0);
    assign unb       = in_exp - EXP_BIAS;
    assign disc_mask = MAN_ONES >> unb;
    assign rb_mask   = disc_mask & ~(disc_mask >> 1);

    // |x|<1 reuses the round/sticky encoding: the leading 1 is the round
    // bit only at exponent BIAS-1, and the kept integer part is zero.
    always_comb begin
        s1_d          = '0;
        s1_d.sign     = in_sign;
        s1_d.exp      = in_exp;
        s1_d.frac     = in_frac;
        s1_d.mode     = rmode_e'(in_mode_i);
        s1_d.tag      = in_tag_i;
        s1_d.cls      = CLS_NORM;
        s1_d.int_mask = ~disc_mask;
        s1_d.rnd      = |(in_frac & rb_mask);
        s1_d.sticky   = |(in_frac & (disc_mask >> 1));
        s1_d.lsb      = (unb == '0) | (|(in_frac & (rb_mask << 1)));
        unique case (1'b1)
            is_pass: begin
                s1_d.cls      = CLS_PASS;
                s1_d.int_mask = MAN_ONES;
                s1_d.rnd      = 1'b0;
                s1_d.sticky   = 1'b0;
                s1_d.lsb      = 1'b0;
            end
            is_small: begin
                s1_d.cls      = CLS_SMALL;
                s1_d.int_mask = '0;
                s1_d.rnd      = in_exp == EXP_HALF;
                s1_d.sticky   = ((in_exp < EXP_HALF) & in_nz)
                              | (in_frac != '0);
                s1_d.lsb      = 1'b0;
            end
            default: ;
        endcase
    end

    assign s2_ready   = ~out_valid_o | out_ready_i;
    assign s1_advance = s1_valid & s2_ready;
    assign in_ready_o = ~s1_valid | s1_advance;

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_q <= s1_d;
            end
        end
    end

    logic             disc;
    logic             inc;
    logic [MAN_W-1:0] kept;
    logic [MAN_W:0]   sum;
    logic [EXP_W-1:0] r_exp;
    logic [MAN_W-1:0] r_frac;
    logic             r_inexact;

    assign disc = s1_q.rnd | s1_q.sticky;
    assign kept = s1_q.frac & s1_q.int_mask;
    assign sum  = {1'b0, kept} + {1'b0, ~s1_q.int_mask}
                + (MAN_W + 1)'(1);

    always_comb begin
        inc = 1'b0;
        unique case (s1_q.mode)
            RM_FLOOR: inc = s1_q.sign & disc;
            RM_CEIL:  inc = ~s1_q.sign & disc;
            RM_TRUNC: inc = 1'b0;
            RM_RNE:   inc = s1_q.rnd & (s1_q.sticky | s1_q.lsb);
        endcase
    end

    // A carry out of the kept field means the magnitude hit the next power
    // of two, so the fraction wraps to zero and the exponent steps up.
    always_comb begin
        r_exp     = s1_q.exp;
        r_frac    = s1_q.frac;
        r_inexact = 1'b0;
        unique case (s1_q.cls)
            CLS_SMALL: begin
                r_exp     = inc ? EXP_BIAS : '0;
                r_frac    = '0;
                r_inexact = disc;
            end
            CLS_NORM: begin
                r_inexact = disc;
                if (!inc) begin
                    r_frac = kept;
                end else if (sum[MAN_W]) begin
                    r_exp  = s1_q.exp + EXP_W'(1);
                    r_frac = '0;
                end else begin
                    r_frac = sum[MAN_W-1:0];
                end
            end
            default: ;
        endcase
    end

    logic [WIDTH-1:0] r_data;

    assign r_data = {s1_q.sign, r_exp, r_frac};

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            out_valid_o   <= 1'b0;
            out_data_o    <= '0;
            out_tag_o     <= '0;
            out_inexact_o <= 1'b0;
        end else if (s2_ready) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                out_data_o    <= r_data;
                out_tag_o     <= s1_q.tag;
                out_inexact_o <= r_inexact;
            end
        end
    end

endmodule
